// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared data width, FSM state type and output-dimension helper
package conv_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      EMIT
   } state_t;

   // Valid-window output side length for an in x in frame, f x f window, stride s.
   function automatic int out_dim(input int in_dim, input int f, input int s);
      return ((in_dim - f) / s) + 1;
   endfunction

endpackage

// File: rtl/maxpool_relu_stream_if.sv
// rtl/maxpool_relu_stream_if.sv - frame-in / result-out handshake bundle for maxpool_relu_stream
interface maxpool_relu_stream_if #(
   parameter int N     = 9,
   parameter int IDX_W = 2
) ();

   logic [conv_pkg::DATA_W-1:0] in_data [N];
   logic                        in_valid;
   logic                        in_ready;
   logic [conv_pkg::DATA_W-1:0] out_data;
   logic [IDX_W-1:0]            out_index;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_index, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_index, out_valid, out_last
   );

endinterface

// File: rtl/max_relu_unit.sv
// rtl/max_relu_unit.sv - signed running-max select plus optional ReLU clamp
module max_relu_unit
   import conv_pkg::*;
#(
   parameter int relu_en = 1
) (
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] elem_i,
   input  logic              first_i,
   output logic [DATA_W-1:0] max_o,
   output logic [DATA_W-1:0] result_o
);

   always_comb begin
      max_o = acc_i;
      // Strictly greater keeps the earliest maximum on ties.
      if (first_i || ($signed(elem_i) > $signed(acc_i))) begin
         max_o = elem_i;
      end
      result_o = max_o;
      if ((relu_en != 0) && max_o[DATA_W-1]) begin
         result_o = '0;
      end
   end

endmodule

// File: rtl/maxpool_relu_stream.sv
// rtl/maxpool_relu_stream.sv - captures a square frame, then streams window maxima one result at a time
module maxpool_relu_stream
   import conv_pkg::*;
#(
   parameter int in_size     = 3,
   parameter int pool_size   = 2,
   parameter int pool_stride = 1,
   parameter int relu_en     = 1,
   localparam int out_size   = out_dim(in_size, pool_size, pool_stride),
   localparam int n_out      = out_size * out_size,
   localparam int IDX_W      = (n_out > 1) ? $clog2(n_out) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data [in_size*in_size],
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int N  = in_size * in_size;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(in_size + 1);
   localparam logic [CW-1:0]    P_LAST   = CW'(pool_size - 1);
   localparam logic [CW-1:0]    O_LAST   = CW'(out_size - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(n_out - 1);

   state_t              state_q;
   logic [DATA_W-1:0]   frame_q [N];
   logic [CW-1:0]       wr_q, wc_q, er_q, ec_q;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   out_data_q, result_d;
   logic [IDX_W-1:0]    out_index_q;
   logic                out_valid_q, out_last_q;

   logic [31:0]         addr_full;
   logic [AW-1:0]       addr;
   logic [DATA_W-1:0]   elem;
   logic                first_elem, last_elem;

   always_comb begin
      addr_full  = (32'(wr_q) * 32'(pool_stride) + 32'(er_q)) * 32'(in_size)
                 + 32'(wc_q) * 32'(pool_stride) + 32'(ec_q);
      addr       = AW'(addr_full);
      elem       = frame_q[addr];
      first_elem = (er_q == '0) && (ec_q == '0);
      last_elem  = (er_q == P_LAST) && (ec_q == P_LAST);
   end

   max_relu_unit #(
      .relu_en (relu_en)
   ) u_max_relu (
      .acc_i    (acc_q),
      .elem_i   (elem),
      .first_i  (first_elem),
      .max_o    (acc_d),
      .result_o (result_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_q        <= '0;
         wc_q        <= '0;
         er_q        <= '0;
         ec_q        <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  frame_q     <= in_data;
                  wr_q        <= '0;
                  wc_q        <= '0;
                  er_q        <= '0;
                  ec_q        <= '0;
                  out_index_q <= '0;
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               acc_q <= acc_d;
               if (last_elem) begin
                  er_q        <= '0;
                  ec_q        <= '0;
                  out_data_q  <= result_d;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (out_index_q == IDX_LAST);
                  state_q     <= EMIT;
               end else if (ec_q == P_LAST) begin
                  ec_q <= '0;
                  er_q <= er_q + CW'(1);
               end else begin
                  ec_q <= ec_q + CW'(1);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     state_q <= IDLE;
                  end else begin
                     // out_index doubles as the window counter; it only moves on a handshake.
                     out_index_q <= out_index_q + IDX_W'(1);
                     if (wc_q == O_LAST) begin
                        wc_q <= '0;
                        wr_q <= wr_q + CW'(1);
                     end else begin
                        wc_q <= wc_q + CW'(1);
                     end
                     state_q <= SCAN;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// tb/tb_maxpool_relu_stream.sv - scoreboard bench: defaults, relu_en=0 and a 7/3/2 sweep instance
module tb_maxpool_relu_stream;

   logic clk;
   logic reset;
   logic out_ready;
   int   sel;
   int   checks;
   int   passed;

   logic [31:0] exp_q [$];
   logic [31:0] fr [$];

   logic        mo_valid, mo_last, mo_in_ready;
   logic [31:0] mo_data, mo_index;

   maxpool_relu_stream_if #(.N(9),  .IDX_W(2)) bus_a ();
   maxpool_relu_stream_if #(.N(9),  .IDX_W(2)) bus_c ();
   maxpool_relu_stream_if #(.N(49), .IDX_W(4)) bus_b ();

   assign bus_a.out_ready = out_ready;
   assign bus_c.out_ready = out_ready;
   assign bus_b.out_ready = out_ready;

   maxpool_relu_stream dut_a (
      .clk(clk), .reset(reset),
      .in_data(bus_a.in_data), .in_valid(bus_a.in_valid), .in_ready(bus_a.in_ready),
      .out_data(bus_a.out_data), .out_index(bus_a.out_index), .out_valid(bus_a.out_valid),
      .out_ready(bus_a.out_ready), .out_last(bus_a.out_last)
   );

   maxpool_relu_stream #(.relu_en(0)) dut_c (
      .clk(clk), .reset(reset),
      .in_data(bus_c.in_data), .in_valid(bus_c.in_valid), .in_ready(bus_c.in_ready),
      .out_data(bus_c.out_data), .out_index(bus_c.out_index), .out_valid(bus_c.out_valid),
      .out_ready(bus_c.out_ready), .out_last(bus_c.out_last)
   );

   maxpool_relu_stream #(.in_size(7), .pool_size(3), .pool_stride(2)) dut_b (
      .clk(clk), .reset(reset),
      .in_data(bus_b.in_data), .in_valid(bus_b.in_valid), .in_ready(bus_b.in_ready),
      .out_data(bus_b.out_data), .out_index(bus_b.out_index), .out_valid(bus_b.out_valid),
      .out_ready(bus_b.out_ready), .out_last(bus_b.out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      mo_valid = bus_a.out_valid; mo_data = bus_a.out_data;
      mo_index = 32'(bus_a.out_index); mo_last = bus_a.out_last; mo_in_ready = bus_a.in_ready;
      if (sel == 1) begin
         mo_valid = bus_c.out_valid; mo_data = bus_c.out_data;
         mo_index = 32'(bus_c.out_index); mo_last = bus_c.out_last; mo_in_ready = bus_c.in_ready;
      end else if (sel == 2) begin
         mo_valid = bus_b.out_valid; mo_data = bus_b.out_data;
         mo_index = 32'(bus_b.out_index); mo_last = bus_b.out_last; mo_in_ready = bus_b.in_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference max-pool over a row-major frame, pushing one expected word per window.
   function automatic void model(input int isz, input int psz, input int st, input bit relu,
                                 input logic [31:0] f [$]);
      int os;
      logic signed [31:0] m, v;
      os = (isz - psz) / st + 1;
      for (int wr = 0; wr < os; wr++) begin
         for (int wc = 0; wc < os; wc++) begin
            m = f[wr * st * isz + wc * st];
            for (int er = 0; er < psz; er++) begin
               for (int ec = 0; ec < psz; ec++) begin
                  v = f[(wr * st + er) * isz + wc * st + ec];
                  if (v > m) m = v;
               end
            end
            if (relu && m < 0) m = 0;
            exp_q.push_back(m);
         end
      end
   endfunction

   task automatic drain(input string tag, input int n, input int nout, input int budget);
      int got;
      int cyc;
      got = 0;
      cyc = 0;
      while (got < n && cyc < budget) begin
         if (mo_valid && out_ready) begin
            chk({tag, "_data"}, mo_data, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            chk({tag, "_index"}, mo_index, 32'(got));
            chk({tag, "_last"}, 32'(mo_last), 32'(got == nout - 1));
            got++;
         end
         tick();
         cyc++;
      end
      chk({tag, "_count"}, 32'(got), 32'(n));
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int cyc;
      cyc = 0;
      while (!mo_valid && cyc < budget) begin
         tick();
         cyc++;
      end
      chk({tag, "_valid_seen"}, 32'(mo_valid), 32'd1);
   endtask

   task automatic seq_frame(input int base);
      fr.delete();
      for (int i = 0; i < 9; i++) fr.push_back(32'(base + i));
   endtask

   task automatic load_a();
      for (int i = 0; i < 9; i++) bus_a.in_data[i] = fr[i];
   endtask

   initial begin
      checks = 0;
      passed = 0;
      sel = 0;
      out_ready = 1'b1;
      reset = 1'b1;
      bus_a.in_valid = 1'b0;
      bus_c.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus_a.in_data[i] = '0;
         bus_c.in_data[i] = '0;
      end
      for (int i = 0; i < 49; i++) bus_b.in_data[i] = '0;
      tick();
      tick();
      chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      chk("rst_out_data",  bus_a.out_data, 32'd0);
      chk("rst_out_index", 32'(bus_a.out_index), 32'd0);
      chk("rst_out_last",  32'(bus_a.out_last), 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);

      // Basic frame 1..9 with latency check.
      seq_frame(1);
      model(3, 2, 1, 1'b1, fr);
      load_a();
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      chk("basic_in_ready_busy", 32'(bus_a.in_ready), 32'd0);
      tick(); tick(); tick();
      chk("basic_lat_valid_lo", 32'(bus_a.out_valid), 32'd0);
      tick();
      chk("basic_lat_valid_hi", 32'(bus_a.out_valid), 32'd1);
      drain("basic", 4, 4, 40);
      chk("basic_in_ready_done", 32'(bus_a.in_ready), 32'd1);

      // ReLU clamps an all -5 frame.
      fr.delete();
      for (int i = 0; i < 9; i++) fr.push_back(32'hFFFF_FFFB);
      model(3, 2, 1, 1'b1, fr);
      load_a();
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      drain("relu_neg", 4, 4, 40);

      // relu_en=0 passes -5 through.
      sel = 1;
      model(3, 2, 1, 1'b0, fr);
      for (int i = 0; i < 9; i++) bus_c.in_data[i] = fr[i];
      bus_c.in_valid = 1'b1;
      tick();
      bus_c.in_valid = 1'b0;
      drain("norelu", 4, 4, 40);
      sel = 0;

      // Most-negative word against 1 in window 0.
      fr.delete();
      for (int i = 0; i < 9; i++) fr.push_back(32'h8000_0000);
      fr[1] = 32'd1;
      fr[8] = 32'hFFFF_FFF0;
      model(3, 2, 1, 1'b1, fr);
      load_a();
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      drain("signed", 4, 4, 40);

      // Back-pressure holds the first result for three cycles.
      seq_frame(1);
      model(3, 2, 1, 1'b1, fr);
      load_a();
      out_ready = 1'b0;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      wait_valid("bp", 20);
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", 32'(mo_valid), 32'd1);
         chk("bp_hold_data", mo_data, exp_q[0]);
         chk("bp_hold_index", mo_index, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      drain("bp", 4, 4, 40);

      // in_valid with another frame while busy is ignored.
      seq_frame(1);
      model(3, 2, 1, 1'b1, fr);
      load_a();
      bus_a.in_valid = 1'b1;
      tick();
      seq_frame(10);
      load_a();
      tick();
      tick();
      chk("busy_in_ready", 32'(bus_a.in_ready), 32'd0);
      drain("busy", 4, 4, 40);
      chk("busy_in_ready_after_last", 32'(bus_a.in_ready), 32'd1);
      bus_a.in_valid = 1'b0;

      // Reset during SCAN of window 2, then a fresh frame.
      seq_frame(1);
      model(3, 2, 1, 1'b1, fr);
      load_a();
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      drain("prerst", 2, 4, 30);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus_a.in_ready), 32'd1);
      exp_q.delete();
      tick(); tick(); tick(); tick(); tick();
      chk("midrst_no_output", 32'(bus_a.out_valid), 32'd0);
      model(3, 2, 1, 1'b1, fr);
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      drain("postrst", 4, 4, 40);

      // Parameter sweep 7/3/2 with random signed frames.
      sel = 2;
      for (int t = 0; t < 2; t++) begin
         fr.delete();
         for (int i = 0; i < 49; i++) fr.push_back($urandom);
         model(7, 3, 2, 1'b1, fr);
         for (int i = 0; i < 49; i++) bus_b.in_data[i] = fr[i];
         bus_b.in_valid = 1'b1;
         tick();
         bus_b.in_valid = 1'b0;
         drain("sweep", 9, 9, 150);
         chk("sweep_in_ready", 32'(mo_in_ready), 32'd1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
